// File: rtl/and_64_pkg.sv
// Shared constants for the and_64 block.
// Optional popcount output is enabled with AND_64_POPCOUNT_EN.
package and_64_pkg;

    localparam int AND_W = 64;
    localparam int POP_W = 7;

    localparam logic [AND_W-1:0] ALL_ONES  = {AND_W{1'b1}};
    localparam logic [AND_W-1:0] ALL_ZEROS = {AND_W{1'b0}};

endpackage

// File: rtl/and_64_popcount.sv
// Combinational 64-bit population count.
// Built as a balanced pairwise adder tree, six levels deep.
module and_64_popcount
    import and_64_pkg::*;
(
    input  logic [AND_W-1:0] i_data,
    output logic [POP_W-1:0] o_count
);

    logic [POP_W-1:0] w_l1 [32];
    logic [POP_W-1:0] w_l2 [16];
    logic [POP_W-1:0] w_l3 [8];
    logic [POP_W-1:0] w_l4 [4];
    logic [POP_W-1:0] w_l5 [2];

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            w_l1[i] = {6'd0, i_data[2*i]}
                    + {6'd0, i_data[2*i+1]};
        end
        for (int i = 0; i < 16; i++) begin
            w_l2[i] = w_l1[2*i] + w_l1[2*i+1];
        end
        for (int i = 0; i < 8; i++) begin
            w_l3[i] = w_l2[2*i] + w_l2[2*i+1];
        end
        for (int i = 0; i < 4; i++) begin
            w_l4[i] = w_l3[2*i] + w_l3[2*i+1];
        end
        for (int i = 0; i < 2; i++) begin
            w_l5[i] = w_l4[2*i] + w_l4[2*i+1];
        end
    end

    assign o_count = w_l5[0] + w_l5[1];

endmodule

// File: rtl/and_64.sv
// 64-bit AND with a registered result, zero/ones flags and valid.
// Define AND_64_POPCOUNT_EN to add the registered popcnt_q output.
module and_64
    import and_64_pkg::*;
#(
    parameter int WIDTH = AND_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             zero_q,
`ifdef AND_64_POPCOUNT_EN
    output logic [POP_W-1:0] popcnt_q,
`endif
    output logic             ones_q
);

    logic [WIDTH-1:0] w_and;
    logic             w_zero;
    logic             w_ones;

    logic [WIDTH-1:0] r_y;
    logic             r_valid;
    logic             r_zero;
    logic             r_ones;

    assign w_and  = a & b;
    assign w_zero = (w_and == ALL_ZEROS);
    assign w_ones = (w_and == ALL_ONES);

    // Result and flags hold while in_valid is low; valid does not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= ALL_ZEROS;
            r_zero  <= 1'b1;
            r_ones  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y    <= w_and;
                r_zero <= w_zero;
                r_ones <= w_ones;
            end
        end
    end

`ifdef AND_64_POPCOUNT_EN
    logic [POP_W-1:0] w_pop;
    logic [POP_W-1:0] r_pop;

    and_64_popcount u_popcount (
        .i_data  (w_and),
        .o_count (w_pop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pop <= '0;
        end else if (in_valid) begin
            r_pop <= w_pop;
        end
    end

    assign popcnt_q = r_pop;
`endif

    assign y         = w_and;
    assign y_q       = r_y;
    assign out_valid = r_valid;
    assign zero_q    = r_zero;
    assign ones_q    = r_ones;

endmodule

// File: tb/tb_and_64.sv
// Scoreboard bench for and_64: driver pushes expected captures,
// monitor pops and compares whenever out_valid is seen.
module tb_and_64;
    import and_64_pkg::*;

    typedef struct {
        logic [63:0] v;
        logic        z;
        logic        o;
        int          p;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] a;
    logic [63:0] b;
    logic        in_valid;
    logic [63:0] y;
    logic [63:0] y_q;
    logic        out_valid;
    logic        zero_q;
    logic        ones_q;
`ifdef AND_64_POPCOUNT_EN
    logic [6:0]  popcnt_q;
`endif

    exp_t q[$];
    exp_t last;
    exp_t rst_exp;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    and_64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .y_q       (y_q),
        .out_valid (out_valid),
        .zero_q    (zero_q),
`ifdef AND_64_POPCOUNT_EN
        .popcnt_q  (popcnt_q),
`endif
        .ones_q    (ones_q)
    );

    function automatic exp_t model(logic [63:0] x, logic [63:0] w);
        exp_t e;
        e.v = x & w;
        e.z = (e.v == 64'd0);
        e.o = (e.v == ~64'd0);
        e.p = 0;
        for (int i = 0; i < 64; i++) begin
            if (e.v[i]) e.p++;
        end
        return e;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_regs(string tag, exp_t e);
        check({tag, ".y_q"}, y_q, e.v);
        check({tag, ".zero_q"}, 64'(zero_q), 64'(e.z));
        check({tag, ".ones_q"}, 64'(ones_q), 64'(e.o));
`ifdef AND_64_POPCOUNT_EN
        check({tag, ".popcnt_q"}, 64'(popcnt_q), 64'(e.p));
`endif
    endtask

    task automatic drive(logic [63:0] x, logic [63:0] w, logic v);
        @(negedge clk);
        a = x;
        b = w;
        in_valid = v;
        #1;
        check("y", y, x & w);
        if (v && rst_n) q.push_back(model(x, w));
    endtask

    // Monitor
    initial begin
        rst_exp = '{v: 64'd0, z: 1'b1, o: 1'b0, p: 0};
        last = rst_exp;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                check_regs("rst", rst_exp);
                check("rst.out_valid", 64'(out_valid), 64'd0);
                q.delete();
                last = rst_exp;
            end else if (out_valid) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL spurious out_valid: got 1 want 0 at %0t", $time);
                end else begin
                    last = q.pop_front();
                    check_regs("cap", last);
                end
            end else begin
                check_regs("hold", last);
            end
            check("excl", 64'(zero_q & ones_q), 64'd0);
        end
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 64'd0;
        b = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(64'h0, 64'h0, 1'b1);
        drive(~64'd0, ~64'd0, 1'b1);
        drive(64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 1'b1);
        drive(64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b1);
        drive(64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 1'b1);
        check("vec028.y", y, 64'h0224422882244220);
        @(posedge clk);
        #1;
        check("vec028.y_q", y_q, 64'h0224422882244220);
`ifdef AND_64_POPCOUNT_EN
        check("vec028.popcnt", 64'(popcnt_q), 64'd14);
`endif

        for (int i = 0; i < 300; i++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if ($urandom_range(0, 7) == 0) rb = ~64'd0;
            if ($urandom_range(0, 7) == 0) ra = ~64'd0;
            drive(ra, rb, 1'($urandom_range(0, 2) != 0));
        end

        drive(64'hDEADBEEFCAFEF00D, 64'hF0F0F0F0FFFF0000, 1'b1);
        drive(64'h1, 64'h3, 1'b0);
        drive(64'h7, 64'h7, 1'b0);

        // Asynchronous reset between edges; y must keep tracking.
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.y_q", y_q, 64'd0);
        check("arst.zero_q", 64'(zero_q), 64'd1);
        check("arst.out_valid", 64'(out_valid), 64'd0);
        a = 64'hFF00FF00FF00FF00;
        b = 64'h0FF00FF00FF00FF0;
        #1;
        check("arst.y", y, 64'h0F000F000F000F00);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(64'h8000000000000001, ~64'd0, 1'b1);
        repeat (3) drive(64'h0, 64'h0, 1'b0);
        @(negedge clk);
        check("drain", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
